// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl -- load/run/dump sequencer for the pipelined MIPS CPU.
//
// Streams a program into instruction RAM and pads the rest with END_WORD.
// Holds the CPU in reset until start. It then runs the CPU until END_WORD is
// fetched or MAX_CYCLES elapse, and drains the pipeline for DRAIN_CYCLES.
// Finally it dumps DUMP_WORDS words of data RAM and raises done.
//
// Ports
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   load_valid/data/last  program word stream in
//   load_ready            word accepted on an edge where load_valid && load_ready
//   start                 begin execution (honoured only in READY)
//   imem_we/addr/wdata    instruction RAM write port
//   cpu_rst, cpu_en       CPU reset and advance enable
//   if_valid, if_instr    fetch-stage instruction, watched for END_WORD
//   dmem_re, dmem_addr    data RAM read port (read data one cycle later)
//   dmem_rdata            data RAM read data
//   dump_valid/addr/data  dumped data RAM words
//   cycle_count           RUN cycles elapsed (detect/timeout cycle included)
//   timeout               run was ended by MAX_CYCLES
//   done                  sequence complete; held until RESET
//
// Handshake: load_ready is a registered output. A word transfers on every
// rising edge where load_valid and load_ready are both high. load_valid is
// ignored whenever load_ready is low.
//
// The FSM state is held in the internal signal 'state' for probing.

module cpu_run_ctrl #(
    parameter int          IMEM_DEPTH   = 512,
    parameter int          DUMP_WORDS   = 512,
    parameter logic [31:0] END_WORD     = 32'hFFFFFFFF,
    parameter int          DRAIN_CYCLES = 5,
    parameter int          MAX_CYCLES   = 0,
    localparam int         IA           = $clog2(IMEM_DEPTH),
    localparam int         DA           = $clog2(DUMP_WORDS)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          start,
    output logic          imem_we,
    output logic [IA-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_rst,
    output logic          cpu_en,
    input  logic          if_valid,
    input  logic [31:0]   if_instr,
    output logic          dmem_re,
    output logic [DA-1:0] dmem_addr,
    input  logic [31:0]   dmem_rdata,
    output logic          dump_valid,
    output logic [DA-1:0] dump_addr,
    output logic [31:0]   dump_data,
    output logic [31:0]   cycle_count,
    output logic          timeout,
    output logic          done
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FILL,
        S_READY,
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_DONE
    } state_t;

    localparam logic [IA-1:0] LAST_IA = IA'(IMEM_DEPTH - 1);
    localparam logic [DA-1:0] LAST_DA = DA'(DUMP_WORDS - 1);

    state_t        state;
    logic [IA-1:0] ptr;        // next instruction RAM address to write
    logic [31:0]   drain_cnt;  // DRAIN cycles already spent, minus one

    logic end_seen;
    logic limit_hit;

    assign end_seen  = if_valid && (if_instr == END_WORD);
    assign limit_hit = (MAX_CYCLES != 0) && ((cycle_count + 32'd1) == 32'(MAX_CYCLES));

    // The data RAM's output register is the register stage for dump_data.
    // Forwarding it keeps the word aligned with dump_valid/dump_addr.
    // Gating keeps it at zero outside a dump beat.
    assign dump_data = dump_valid ? dmem_rdata : 32'd0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_LOAD;
            ptr         <= '0;
            drain_cnt   <= '0;
            load_ready  <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_rst     <= 1'b1;
            cpu_en      <= 1'b0;
            dmem_re     <= 1'b0;
            dmem_addr   <= '0;
            dump_valid  <= 1'b0;
            dump_addr   <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Single-cycle strobes.
            imem_we    <= 1'b0;
            dump_valid <= 1'b0;

            case (state)
                S_LOAD: begin
                    load_ready <= 1'b1;
                    if (load_valid && load_ready) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= load_data;
                        ptr        <= ptr + IA'(1);
                        // A full RAM ends loading whether or not load_last is set.
                        if (ptr == LAST_IA) begin
                            load_ready <= 1'b0;
                            state      <= S_READY;
                        end else if (load_last) begin
                            load_ready <= 1'b0;
                            state      <= S_FILL;
                        end
                    end
                end

                S_FILL: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= END_WORD;
                    ptr        <= ptr + IA'(1);
                    if (ptr == LAST_IA) begin
                        state <= S_READY;
                    end
                end

                S_READY: begin
                    if (start) begin
                        cpu_rst <= 1'b0;
                        cpu_en  <= 1'b1;
                        state   <= S_RUN;
                    end
                end

                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    // End detect takes priority over the cycle limit.
                    if (end_seen || limit_hit) begin
                        if (!end_seen) begin
                            timeout <= 1'b1;
                        end
                        if (DRAIN_CYCLES == 0) begin
                            cpu_en    <= 1'b0;
                            dmem_re   <= 1'b1;
                            dmem_addr <= '0;
                            state     <= S_DUMP;
                        end else begin
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == 32'(DRAIN_CYCLES - 1)) begin
                        cpu_en    <= 1'b0;
                        dmem_re   <= 1'b1;
                        dmem_addr <= '0;
                        state     <= S_DUMP;
                    end else begin
                        drain_cnt <= drain_cnt + 32'd1;
                    end
                end

                S_DUMP: begin
                    // Each read issued last cycle becomes a dump beat now.
                    dump_valid <= dmem_re;
                    dump_addr  <= dmem_addr;
                    if (dmem_re) begin
                        if (dmem_addr == LAST_DA) begin
                            dmem_re <= 1'b0;
                        end else begin
                            dmem_addr <= dmem_addr + DA'(1);
                        end
                    end else begin
                        // The last beat is on the outputs this cycle.
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done <= 1'b1;
                end

                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
